mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Multicycle load/store sequencer between the datapath and the single-port word memory. On a start pulse it performs a byte, halfword or word load or store, including read-modify-write for sub-word stores. For loads it produces the extended 32-bit `load_data` word that the writeback selector takes on its load-data input (select 3'b001). Stores leave `load_data` unchanged.

## Interface
Parameters:
- READ_LATENCY, 1: cycles from memory address presented to `mem_rdata` valid; legal range 1..3.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  3  000 LW, 001 LH, 010 LB, 011 LHU, 100 SW, 101 SH, 110 SB, 111 LBU.
- addr  in  32  byte address; sampled with start.
- wdata  in  32  store source (register B); sampled with start; low byte or halfword used for SB/SH.
- mem_addr  out  32  word-aligned address {addr_q[31:2],2'b00}.
- mem_wr  out  1  write enable; high for exactly one cycle per store.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- addr_err  out  1  one-cycle pulse with done on a misaligned request.
- load_data  out  32  registered load result; holds until the next completed load.

## Operation
- Byte order is little-endian: byte k = word[8k+7:8k], and k = addr[1:0]. A halfword uses bytes {addr[1]*2+1, addr[1]*2}.
- Extension rules:
  - LB and LH sign-extend from bit 7 or bit 15.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Alignment errors:
  - LW and SW require addr[1:0]==0.
  - LH, LHU and SH require addr[0]==0.
  - Byte ops never fault.
  - On a fault: no memory access, mem_wr stays 0, load_data is unchanged, addr_err=1 and done=1.
- States:
  - IDLE: start=1 latches op/addr/wdata. Next state is ERR if misaligned, WR if SW, otherwise RD.
  - RD: drives mem_addr, mem_wr=0, counts READ_LATENCY cycles, then goes to CAP.
  - CAP: on a load, registers the extended result into load_data and goes to DONE. On SH/SB, registers the merged word (old word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]) and goes to WR.
  - WR: mem_wr=1, mem_wdata is wdata (SW) or the merged word; goes to DONE.
  - DONE and ERR: one cycle each, done=1 (addr_err=1 in ERR only), then IDLE.
- start while busy is ignored, with no queuing.
- mem_addr is held stable from RD entry through WR. It is 0 in IDLE.

## Timing
- start accepted at the edge ending cycle T. In all cases below, busy=1 from T+1 until the done cycle inclusive, and done is a single cycle.
  - Loads (L=READ_LATENCY): RD occupies T+1..T+L, CAP is T+L+1, and done with the new load_data is at T+L+2.
  - SW: WR at T+1, done at T+2.
  - SH/SB: RD T+1..T+L, CAP T+L+1, WR T+L+2, done at T+L+3.
  - Misaligned: ERR at T+1, so done and addr_err are at T+1.
- A new start is accepted in the cycle after done, which gives back-to-back throughput.
- Reset values: state IDLE; mem_addr, mem_wdata and load_data 0; mem_wr, busy, done and addr_err 0.
- Reset mid-operation aborts the operation with no done pulse, and mem_wr is 0 from the cycle after the reset edge. A write whose WR cycle coincides with the reset edge is committed by memory.
- reset has priority over start in the same cycle.

## Structure
- The shared package `mips_pkg` holds:
  - the op encodings (OP_LW..OP_LBU),
  - the state enum {IDLE,RD,CAP,WR,DONE,ERR},
  - the lane-select helper constants.
- One combinational sub-module, `ls_lane`: inputs word, addr[1:0], op, wdata; outputs the extended load value, the merged store word and a misaligned flag. The top level holds the FSM, the latency counter and the registers.

## Test plan
- READ_LATENCY=1, memory word at 0x40 = 0x80FF7F01:
  - LB at 0x43 gives load_data 0xFFFFFF80 with done at T+3.
  - LBU at 0x43 gives 0x00000080.
- LH at 0x42 on the same word gives 0xFFFF80FF; LHU gives 0x000080FF; LW at 0x40 gives 0x80FF7F01.
- SB at 0x41 with wdata 0x000000AA on word 0x11223344: exactly one mem_wr pulse with mem_wdata 0x1122AA44 at T+3, and done at T+4.
- SW at 0x44 with 0xDEADBEEF: mem_wr at T+1 with mem_addr 0x44, and done at T+2. A start pulsed during busy is ignored.
- LW at 0x42 and SH at 0x41: done and addr_err at T+1, no mem_wr, and load_data unchanged.
- READ_LATENCY=3 SH with reset asserted during RD: no done pulse, no mem_wr, all outputs 0. The next LW completes normally at T+5.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the load/store sequencer: op encodings, FSM states
// and lane-select helpers.
package mips_pkg;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LB  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_SH  = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_LBU = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE,
        ERR
    } state_e;

    localparam logic [3:0] LANE_BYTE = 4'b0001;
    localparam logic [3:0] LANE_HALF = 4'b0011;
    localparam logic [3:0] LANE_WORD = 4'b1111;

    function automatic logic op_is_store(logic [2:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    // Byte lanes written by a store at byte offset a within the word.
    function automatic logic [3:0] lane_mask(logic [2:0] op, logic [1:0] a);
        logic [3:0] base;
        case (op)
            OP_SB:   base = LANE_BYTE;
            OP_SH:   base = LANE_HALF;
            default: base = LANE_WORD;
        endcase
        return base << a;
    endfunction

endpackage

// File: rtl/ls_lane.sv
// Combinational lane logic: load extraction/extension, sub-word store merge
// and alignment check for one memory word.
module ls_lane (
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  op,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word,
    output logic        misaligned
);
    import mips_pkg::*;

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] rep;
    logic [3:0]  mask;

    assign byte_v = word[{addr, 3'b000} +: 8];
    assign half_v = word[{addr[1], 4'b0000} +: 16];
    assign mask   = lane_mask(op, addr);

    always_comb begin
        load_val = '0;
        case (op)
            OP_LW:   load_val = word;
            OP_LH:   load_val = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_val = {16'h0000, half_v};
            OP_LB:   load_val = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_val = {24'h000000, byte_v};
            default: load_val = '0;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (op)
            OP_LW, OP_SW:         misaligned = (addr != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
            default:              misaligned = 1'b0;
        endcase
    end

    // Replicate the source across all lanes, then keep only the addressed ones.
    always_comb begin
        rep = wdata;
        case (op)
            OP_SB:   rep = {4{wdata[7:0]}};
            OP_SH:   rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
    end

    always_comb begin
        store_word = word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                store_word[8*i +: 8] = rep[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle load/store sequencer between the datapath and a single-port word
// memory, with read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        addr_err,
    output logic [31:0] load_data
);
    import mips_pkg::*;

    localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;
    logic [31:0] load_data_q;

    logic        latch_req;
    logic        cap_load;
    logic        cap_merge;

    logic [1:0]  lane_addr;
    logic [2:0]  lane_op;
    logic [31:0] lane_load;
    logic [31:0] lane_store;
    logic        lane_mis;

    // In IDLE the lane checks the incoming request; afterwards the latched one.
    assign lane_addr = (state_q == IDLE) ? addr[1:0] : addr_q[1:0];
    assign lane_op   = (state_q == IDLE) ? op : op_q;

    ls_lane u_lane (
        .word       (mem_rdata),
        .addr       (lane_addr),
        .op         (lane_op),
        .wdata      (wdata_q),
        .load_val   (lane_load),
        .store_word (lane_store),
        .misaligned (lane_mis)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_req = 1'b0;
        cap_load  = 1'b0;
        cap_merge = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    latch_req = 1'b1;
                    cnt_d     = 2'd0;
                    if (lane_mis) begin
                        state_d = ERR;
                    end else if (op == OP_SW) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = CAP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            CAP: begin
                if (op_is_store(op_q)) begin
                    cap_merge = 1'b1;
                    state_d   = WR;
                end else begin
                    cap_load = 1'b1;
                    state_d  = DONE;
                end
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            op_q        <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            merged_q    <= '0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_req) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (cap_merge) begin
                merged_q <= lane_store;
            end
            if (cap_load) begin
                load_data_q <= lane_load;
            end
        end
    end

    always_comb begin
        mem_addr = '0;
        if (state_q == RD || state_q == CAP || state_q == WR) begin
            mem_addr = {addr_q[31:2], 2'b00};
        end
    end

    always_comb begin
        mem_wdata = '0;
        if (state_q == WR) begin
            mem_wdata = (op_q == OP_SW) ? wdata_q : merged_q;
        end
    end

    assign mem_wr    = (state_q == WR);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE) || (state_q == ERR);
    assign addr_err  = (state_q == ERR);
    assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (read latency 1 and 3) against a
// transaction-level reference model, plus directed literal checks.
module tb_mem_access_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start [2];
    logic [2:0]  op [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] mem_addr [2];
    logic        mem_wr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        busy [2];
    logic        done [2];
    logic        addr_err [2];
    logic [31:0] load_data [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit #(.READ_LATENCY(1)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .op(op[0]), .addr(addr[0]),
        .wdata(wdata[0]), .mem_addr(mem_addr[0]), .mem_wr(mem_wr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0]),
        .done(done[0]), .addr_err(addr_err[0]), .load_data(load_data[0])
    );

    mem_access_unit #(.READ_LATENCY(3)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .op(op[1]), .addr(addr[1]),
        .wdata(wdata[1]), .mem_addr(mem_addr[1]), .mem_wr(mem_wr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1]),
        .done(done[1]), .addr_err(addr_err[1]), .load_data(load_data[1])
    );

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] init_word(int d, int i);
        if (i == 16) return (d == 0) ? 32'h80FF7F01 : 32'h11223344;
        return 32'h0;
    endfunction

    task automatic check(input int d, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cyc %0d: got %h, expected %h", name, d, cyc, act, exp);
        end
    endtask

    // Memory models: synchronous write, read data valid READ_LATENCY cycles later.
    logic [31:0] mem [2][64];
    logic [31:0] apipe [2][3];
    int          wr_cnt [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            wr_cnt[d] <= 0;
            for (int k = 0; k < 3; k++) apipe[d][k] <= '0;
            for (int i = 0; i < 64; i++) mem[d][i] <= init_word(d, i);
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (mem_wr[d] === 1'b1) begin
                    mem[d][mem_addr[d][7:2]] <= mem_wdata[d];
                    wr_cnt[d] <= wr_cnt[d] + 1;
                end
                apipe[d][0] <= mem_addr[d];
                apipe[d][1] <= apipe[d][0];
                apipe[d][2] <= apipe[d][1];
            end
        end
    end

    assign mem_rdata[0] = mem[0][apipe[0][0][7:2]];
    assign mem_rdata[1] = mem[1][apipe[1][2][7:2]];

    // Reference model: one pending transaction per instance, described by the
    // cycles at which its write and done occur.
    bit          m_act [2];
    bit          m_err [2];
    bit          m_load [2];
    int          m_done [2];
    int          m_wr [2];
    logic [31:0] m_maddr [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_ldnew [2];
    logic [31:0] m_ldcur [2];
    logic [31:0] ref_mem [2][64];

    task automatic accept(input int d);
        logic [31:0] a, w, b, h, sh;
        int L;
        bit mis;
        a = addr[d];
        w = ref_mem[d][a[7:2]];
        L = lat_of(d);
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        m_act[d] = 1'b1;
        m_err[d] = 1'b0;
        m_load[d] = 1'b0;
        m_wr[d] = -1;
        m_maddr[d] = a & 32'hFFFF_FFFC;
        mis = ((op[d] == OP_LW || op[d] == OP_SW) && (a % 4 != 0)) ||
              ((op[d] == OP_LH || op[d] == OP_LHU || op[d] == OP_SH) && (a % 2 != 0));
        if (mis) begin
            m_err[d] = 1'b1;
            m_done[d] = cyc + 1;
        end else begin
            case (op[d])
                OP_SW: begin
                    m_wr[d] = cyc + 1;
                    m_done[d] = cyc + 2;
                    m_wdata[d] = wdata[d];
                end
                OP_SB: begin
                    sh = 8 * a[1:0];
                    m_wr[d] = cyc + L + 2;
                    m_done[d] = cyc + L + 3;
                    m_wdata[d] = (w & ~(32'hFF << sh)) | ((wdata[d] & 32'hFF) << sh);
                end
                OP_SH: begin
                    sh = 16 * a[1];
                    m_wr[d] = cyc + L + 2;
                    m_done[d] = cyc + L + 3;
                    m_wdata[d] = (w & ~(32'hFFFF << sh)) | ((wdata[d] & 32'hFFFF) << sh);
                end
                default: begin
                    m_load[d] = 1'b1;
                    m_done[d] = cyc + L + 2;
                    case (op[d])
                        OP_LB:   m_ldnew[d] = b - ((b >= 128) ? 32'd256 : 32'd0);
                        OP_LBU:  m_ldnew[d] = b;
                        OP_LH:   m_ldnew[d] = h - ((h >= 32768) ? 32'd65536 : 32'd0);
                        OP_LHU:  m_ldnew[d] = h;
                        default: m_ldnew[d] = w;
                    endcase
                end
            endcase
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0;
            m_ldcur[d] = '0;
            m_wr[d] = -1;
            m_done[d] = 0;
            for (int i = 0; i < 64; i++) ref_mem[d][i] = init_word(d, i);
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                // A write in its last cycle lands even if reset hits that edge.
                if (m_act[d] && cyc == m_wr[d]) ref_mem[d][m_maddr[d][7:2]] = m_wdata[d];
                if (reset) begin
                    m_act[d] = 1'b0;
                    m_ldcur[d] = '0;
                end else if (m_act[d]) begin
                    if (cyc == m_done[d]) begin
                        if (m_load[d]) m_ldcur[d] = m_ldnew[d];
                        m_act[d] = 1'b0;
                    end
                end else if (start[d] === 1'b1) begin
                    accept(d);
                end
            end
            cyc++;
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 2; d++) begin
                    bit is_done, is_wr;
                    is_done = m_act[d] && (cyc == m_done[d]);
                    is_wr = m_act[d] && (cyc == m_wr[d]);
                    check(d, "busy", busy[d], m_act[d]);
                    check(d, "done", done[d], is_done);
                    check(d, "addr_err", addr_err[d], is_done && m_err[d]);
                    check(d, "mem_wr", mem_wr[d], is_wr);
                    if (is_wr) check(d, "mem_wdata", mem_wdata[d], m_wdata[d]);
                    if (!m_act[d]) check(d, "mem_addr_idle", mem_addr[d], 32'h0);
                    else if (!m_err[d] && cyc < m_done[d])
                        check(d, "mem_addr", mem_addr[d], m_maddr[d]);
                    check(d, "load_data", load_data[d],
                          (is_done && m_load[d]) ? m_ldnew[d] : m_ldcur[d]);
                end
            end
        end
    end

    // Launch one request in the next cycle and wait (bounded) for its done.
    task automatic do_op(input int d, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] w, input bit poke, input int exp_lat);
        int t, lat;
        @(posedge clk);
        #1;
        start[d] = 1'b1;
        op[d] = o;
        addr[d] = a;
        wdata[d] = w;
        t = cyc;
        @(posedge clk);
        #1;
        if (poke) begin
            op[d] = OP_LW;
            addr[d] = 32'h40;
        end else begin
            start[d] = 1'b0;
        end
        lat = -1;
        for (int n = 1; n <= 12; n++) begin
            if (n == 2) start[d] = 1'b0;
            if (done[d] === 1'b1) begin
                lat = cyc - t;
                break;
            end
            @(posedge clk);
            #1;
        end
        start[d] = 1'b0;
        check(d, "done_latency", lat, exp_lat);
    endtask

    initial begin
        int w0;
        #100000;
        $display("FAIL timeout: bench did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        int w0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            op[d] = 3'b000;
            addr[d] = '0;
            wdata[d] = '0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            check(d, "rst_busy", busy[d], 1'b0);
            check(d, "rst_done", done[d], 1'b0);
            check(d, "rst_mem_wr", mem_wr[d], 1'b0);
            check(d, "rst_mem_addr", mem_addr[d], 32'h0);
            check(d, "rst_load_data", load_data[d], 32'h0);
        end

        // Loads from 0x80FF7F01 at 0x40.
        do_op(0, OP_LB, 32'h43, 32'h0, 1'b0, 3);
        check(0, "lb_43", load_data[0], 32'hFFFFFF80);
        do_op(0, OP_LBU, 32'h43, 32'h0, 1'b0, 3);
        check(0, "lbu_43", load_data[0], 32'h00000080);
        do_op(0, OP_LH, 32'h42, 32'h0, 1'b0, 3);
        check(0, "lh_42", load_data[0], 32'hFFFF80FF);
        do_op(0, OP_LHU, 32'h42, 32'h0, 1'b0, 3);
        check(0, "lhu_42", load_data[0], 32'h000080FF);
        do_op(0, OP_LW, 32'h40, 32'h0, 1'b0, 3);
        check(0, "lw_40", load_data[0], 32'h80FF7F01);

        // SW with a second start pulsed while busy.
        w0 = wr_cnt[0];
        do_op(0, OP_SW, 32'h44, 32'hDEADBEEF, 1'b1, 2);
        check(0, "sw_44_mem", mem[0][17], 32'hDEADBEEF);
        check(0, "sw_44_wr_count", wr_cnt[0] - w0, 1);
        check(0, "sw_keeps_load_data", load_data[0], 32'h80FF7F01);

        do_op(0, OP_SW, 32'h40, 32'h11223344, 1'b0, 2);
        w0 = wr_cnt[0];
        do_op(0, OP_SB, 32'h41, 32'h000000AA, 1'b0, 4);
        check(0, "sb_41_mem", mem[0][16], 32'h1122AA44);
        check(0, "sb_41_wr_count", wr_cnt[0] - w0, 1);
        do_op(0, OP_SH, 32'h42, 32'h00005566, 1'b0, 4);
        check(0, "sh_42_mem", mem[0][16], 32'h5566AA44);

        // Misaligned requests.
        w0 = wr_cnt[0];
        do_op(0, OP_LW, 32'h42, 32'h0, 1'b0, 1);
        check(0, "lw_42_addr_err", addr_err[0], 1'b1);
        check(0, "lw_42_load_data", load_data[0], 32'h80FF7F01);
        do_op(0, OP_SH, 32'h41, 32'h1234, 1'b0, 1);
        check(0, "sh_41_addr_err", addr_err[0], 1'b1);
        check(0, "misaligned_no_wr", wr_cnt[0] - w0, 0);
        check(0, "sh_41_mem", mem[0][16], 32'h5566AA44);

        do_op(0, OP_LHU, 32'h46, 32'h0, 1'b0, 3);
        check(0, "lhu_46", load_data[0], 32'h0000DEAD);
        do_op(0, OP_LB, 32'h45, 32'h0, 1'b0, 3);
        check(0, "lb_45", load_data[0], 32'hFFFFFFBE);

        // Latency-3 instance: SH aborted by reset during RD.
        w0 = wr_cnt[1];
        @(posedge clk);
        #1;
        start[1] = 1'b1;
        op[1] = OP_SH;
        addr[1] = 32'h40;
        wdata[1] = 32'h0000BEEF;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
        check(1, "sh_rd_busy", busy[1], 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check(1, "abort_busy", busy[1], 1'b0);
        check(1, "abort_done", done[1], 1'b0);
        check(1, "abort_mem_wr", mem_wr[1], 1'b0);
        check(1, "abort_mem_addr", mem_addr[1], 32'h0);
        check(1, "abort_mem_wdata", mem_wdata[1], 32'h0);
        check(1, "abort_load_data", load_data[1], 32'h0);
        check(0, "abort_load_data_dut0", load_data[0], 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check(1, "abort_no_wr", wr_cnt[1] - w0, 0);
        check(1, "abort_mem", mem[1][16], 32'h11223344);
        do_op(1, OP_LW, 32'h40, 32'h0, 1'b0, 5);
        check(1, "lw_lat3", load_data[1], 32'h11223344);
        do_op(1, OP_SB, 32'h43, 32'h0000007E, 1'b0, 6);
        check(1, "sb_lat3_mem", mem[1][16], 32'h7E223344);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
